mult_arb_seq: RTL
=================

Name: mult_arb_seq

Overview:
Shared sequential shift-add multiplier with a two-requester round-robin arbiter and controller.
- Accepts one SIZE x SIZE unsigned multiply at a time from either requester.
- Runs SIZE shift-add steps on a single datapath and returns the 2*SIZE-bit product with the requester ID.
- Sits between two client blocks that previously each carried their own combinational multiplier.

Parameters:
SIZE, 8, operand width in bits; product is 2*SIZE bits
CNT_W, 4, step-counter width; must satisfy 2^CNT_W > SIZE

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  2  per-requester request valid; bit i = requester i
req_ready  output  2  per-requester accept; at most one bit high
a0  input  SIZE  multiplicand, requester 0
b0  input  SIZE  multiplier, requester 0
a1  input  SIZE  multiplicand, requester 1
b1  input  SIZE  multiplier, requester 1
rsp_valid  output  1  product valid
rsp_ready  input  1  consumer accepts product
rsp_id  output  1  requester that issued the operation
outcome  output  2*SIZE  product

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, rsp_valid=0, outcome=0, rsp_id=0, req_ready=0, last_grant=1 (so requester 0 wins first), counter=0. Any operation in flight is aborted and produces no response.
- States: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Only one req_valid bit high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - req_ready[grant] is driven combinationally high in IDLE only. Handshake = req_valid[i] & req_ready[i].
- IDLE, on handshake:
  - Latch temp_a = zero-extended a_i (2*SIZE bits), temp_b = b_i, acc = 0, rsp_id = i, last_grant = i, counter = 0.
  - Go to RUN.
- RUN, each edge:
  - If temp_b[0]: acc += temp_a, modulo 2^(2*SIZE); no overflow is possible for unsigned operands.
  - temp_a <<= 1; temp_b >>= 1; counter++.
  - When counter reaches SIZE-1 on this edge: go to DONE and copy the final acc to outcome.
- DONE:
  - rsp_valid=1; outcome and rsp_id are held stable.
  - On rsp_valid & rsp_ready: go to IDLE and clear rsp_valid.
  - rsp_ready low holds DONE indefinitely (backpressure). req_ready stays 0 throughout.
- Latency: the response becomes visible after SIZE+1 rising edges counted from the accepting edge. No back-to-back acceptance: the earliest next accept is the edge after the response handshake, i.e. IDLE for at least one cycle.
- A request that drops req_valid before being granted is simply not taken; there is no request queuing.
- Operands equal to 0 still take the full SIZE steps unless the optional feature is compiled in.
- outcome holds its last value in IDLE and RUN; it is updated only on entry to DONE.
- Single driver per register: every state register is written in one clocked process only.

Optional Feature:
Macro MULT_ARB_EARLY_TERM_EN.
- Defined: in RUN, if the shifted temp_b would become 0 after the current step, go to DONE on that edge.
  - Latency = (index of highest set bit of b) + 2 edges.
  - b=0 completes after 2 edges with outcome=0.
- Undefined: fixed SIZE-step latency as above.
- Products are identical either way.

Decomposition:
- Package mult_arb_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - SIZE default constant;
  - helper constant PROD_W = 2*SIZE.
- One natural sub-module: mult_shift_add_core, containing the temp_a/temp_b/acc registers and one-step logic, with load/step inputs and a done output.
- Arbiter, FSM and handshake logic stay in mult_arb_seq.

Test Plan:
- Single request: req0 with a0=15, b0=21 -> req_ready[0] high that cycle; rsp_valid after 9 edges; outcome=315, rsp_id=0.
- Contention after reset: both valid, req0 (28x21), req1 (255x255) -> req0 served first (outcome=588, id 0), then req1 (outcome=65025, id 1).
- Fairness: both requesters held valid for 4 operations -> grant order 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, outcome and rsp_id stable; req_ready stays 00; release -> IDLE next edge.
- Reset mid-RUN: rst_n=0 at step 4 -> next edge: IDLE, rsp_valid=0, outcome=0; no stale response afterwards.
- With MULT_ARB_EARLY_TERM_EN: a=200, b=1 -> outcome=200 after 2 edges; b=128 -> 25600 after 9 edges; b=0 -> 0 after 2 edges.

Source files
------------

// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Purpose  : Shared types and default sizes for the arbitrated multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

  localparam int unsigned SIZE_DEFAULT  = 8;
  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam int unsigned PROD_W        = 2 * SIZE_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_shift_add_core.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add_core
// Purpose  : One-bit-per-cycle shift-add datapath. With MULT_ARB_EARLY_TERM_EN
//            defined, finishes as soon as the remaining multiplier bits are 0.
// Revision : 1.0 - initial release
// ============================================================================
module mult_shift_add_core #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              done,
  output logic [2*SIZE-1:0] acc_next
);

  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(SIZE - 1);

  logic [2*SIZE-1:0] r_temp_a;
  logic [2*SIZE-1:0] r_acc;
  logic [SIZE-1:0]   r_temp_b;
  logic [SIZE-1:0]   w_temp_b_next;
  logic [CNT_W-1:0]  r_cnt;

  always_comb begin
    w_temp_b_next = r_temp_b >> 1;
    acc_next      = r_temp_b[0] ? (r_acc + r_temp_a) : r_acc;
`ifdef MULT_ARB_EARLY_TERM_EN
    // The step counter still bounds the run; remaining zero bits end it early.
    done = step && ((w_temp_b_next == '0) || (r_cnt == c_last_step));
`else
    done = step && (r_cnt == c_last_step);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_temp_a <= '0;
      r_temp_b <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_temp_a <= {{SIZE{1'b0}}, a};
      r_temp_b <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (step) begin
      r_acc    <= acc_next;
      r_temp_a <= r_temp_a << 1;
      r_temp_b <= w_temp_b_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_arb_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_seq
// Purpose  : Two-requester round-robin front end for a shared sequential
//            multiplier. Optional early termination: MULT_ARB_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arb_seq
  import mult_arb_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [SIZE-1:0]   a0,
  input  logic [SIZE-1:0]   b0,
  input  logic [SIZE-1:0]   a1,
  input  logic [SIZE-1:0]   b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [2*SIZE-1:0] outcome
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;
  logic              r_rsp_id;
  logic [2*SIZE-1:0] r_outcome;
  logic              w_grant;
  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_core_done;
  logic [2*SIZE-1:0] w_acc_next;

  always_comb begin
    w_state_next = r_state;
    req_ready    = 2'b00;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    // Under contention the requester not served last wins.
    w_grant      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    case (r_state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[w_grant] = 1'b1;
          w_accept           = 1'b1;
          w_load             = 1'b1;
          w_state_next       = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_core_done) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_outcome    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_rsp_id     <= w_grant;
      end
      if (w_core_done) begin
        r_outcome <= w_acc_next;
      end
    end
  end

  mult_shift_add_core #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .step     (w_step),
    .a        (w_grant ? a1 : a0),
    .b        (w_grant ? b1 : b0),
    .done     (w_core_done),
    .acc_next (w_acc_next)
  );

  assign rsp_id  = r_rsp_id;
  assign outcome = r_outcome;

endmodule
`default_nettype wire
